multicycle_control: RTL and testbench
=====================================

# multicycle_control

- Multicycle main controller for the load/store datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select, and generates `alu_control` for the ALU, which is the consumer of this block's outputs.
- Supports lw, sw, R-type (add/sub/and/or/slt), beq and j. The ALU's `zero` flag is fed back to resolve beq.

## Interface
Parameters:
- `STATE_W`, 4: width of the state register and `state` debug port.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; sampled only in DECODE.
- `funct`  in  6  IR[5:0]; used in EXECUTE.
- `zero`  in  1  ALU zero flag; used in BRANCH.
- `alu_control`  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write`, `reg_write`  out  1 each  enables.
- `reg_dst`  out  1  write register select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- `pc_write`, `pc_write_cond`  out  1 each  PC update enables.
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `state`  out  STATE_W  current state, for debug.

## Operation
- Moore controller. All outputs decode from the state register. Inputs are used only for next-state selection and for the `alu_control`, `illegal_op` and `pc_write_cond` qualification described below.
- Values not listed below are 0, with `alu_control` = 010.

States and actions:
- FETCH(0): `iord`=0, `mem_read`, `ir_write`, `alu_src_a`=0, `alu_src_b`=01, ADD, `pc_source`=00, `pc_write`. Next state: DECODE.
- DECODE(1): `alu_src_a`=0, `alu_src_b`=11, ADD (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 -> MEM_ADDR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - otherwise -> FETCH, with `illegal_op`=1 in that DECODE cycle.
- MEM_ADDR(2): `alu_src_a`=1, `alu_src_b`=10, ADD. Next state: MEM_READ if lw, MEM_WRITE if sw (opcode is held stable by IR).
- MEM_READ(3): `iord`=1, `mem_read`. Next state: MEM_WB.
- MEM_WB(4): `reg_write`, `reg_dst`=0, `mem_to_reg`=1, `instr_done`. Next state: FETCH.
- MEM_WRITE(5): `iord`=1, `mem_write`, `instr_done`. Next state: FETCH.
- EXECUTE(6): `alu_src_a`=1, `alu_src_b`=00, `alu_control` from the funct decode:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - otherwise -> 010, with `illegal_op`=1 and next state FETCH (no writeback).
  - Legal funct: next state ALU_WB.
- ALU_WB(7): `reg_write`, `reg_dst`=1, `mem_to_reg`=0, `instr_done`. Next state: FETCH.
- BRANCH(8): `alu_src_a`=1, `alu_src_b`=00, SUB, `pc_write_cond`, `pc_source`=01, `instr_done`. Effective PC write = `pc_write_cond` & `zero` (performed by the datapath). Next state: FETCH.
- JUMP(9): `pc_write`, `pc_source`=10, `instr_done`. Next state: FETCH.
- Unused encodings 10-15: all enables 0; next state FETCH.

## Timing
- Reset:
  - `rst_n` low asynchronously forces state to FETCH.
  - While `rst_n`=0, all enables, `instr_done` and `illegal_op` are forced to 0; `alu_control`=010, all selects 0.
  - The first FETCH actions occur in the first cycle after the `rst_n` rise.
- Reset asserted mid-instruction aborts it immediately. No partial writeback is issued after reset.
- Instruction cycle counts, each ending with a return to FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - beq 3
  - j 3
  - illegal opcode 2
  - illegal funct 3
- Exactly one `instr_done` pulse per legal instruction. `instr_done` is never asserted in the same cycle as `illegal_op`.
- `mem_read` and `mem_write` are never both high. `pc_write` and `pc_write_cond` are never both high.
- Outputs are glitch-free with respect to state only: in EXECUTE, `alu_control` may change combinationally with `funct`.

## Structure
- Shared package holds:
  - state encodings, STATE_W
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J
  - funct constants
  - ALU control codes ALU_AND/OR/ADD/SUB/SLT (shared with the ALU).
- Sub-module `alu_decoder`: combinational. Inputs are a 2-bit alu_op (00 add, 01 sub, 10 funct) and `funct`. Outputs are `alu_control` and `funct_illegal`. The main FSM drives alu_op per state.

## Test plan
- Reset mid-MEM_READ: `rst_n`=0 for 2 cycles, then released -> all enables 0 during reset; `state`=0 and FETCH actions in the cycle after release.
- lw (opcode 100011) -> states 0,1,2,3,4,0.
  - `mem_read` in cycles 0 and 3.
  - `reg_write`, `mem_to_reg`=1 only in cycle 4.
  - One `instr_done`.
- R-type with funct 101010 -> `alu_control`=111 in EXECUTE; `reg_write`, `reg_dst`=1 in ALU_WB.
  - Repeat for funct 100010 -> 110, and funct 100100 -> 000.
- beq, tested twice:
  - with `zero`=1 -> `pc_write_cond`=1, `pc_source`=01, `alu_control`=110 in state 8;
  - with `zero`=0 -> identical control outputs. The PC-hold check is done at the datapath level.
- Illegal cases:
  - Opcode 111111 -> `illegal_op` pulse in DECODE, then FETCH; no `reg_write` or `mem_write` at any point.
  - R-type with funct 000111 -> `illegal_op` in EXECUTE; next state FETCH; no `instr_done`.
- Back-to-back sw, j, sw -> cycle counts 4, 3, 4; `mem_write` high exactly in the two MEM_WRITE cycles; `pc_source`=10 in JUMP.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state, opcode, funct and ALU control encodings shared by the controller and ALU
package multicycle_control_pkg;
  localparam int STATE_W = 4;
  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_t;
  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: maps the controller's alu_op and the instruction funct field to an ALU control code
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_funct_illegal
);
  always_comb begin
    o_alu_control   = ALU_ADD;
    o_funct_illegal = 1'b0;
    if (i_alu_op == ALUOP_SUB) o_alu_control = ALU_SUB;
    else if (i_alu_op == ALUOP_FUNCT) begin
      case (i_funct)
        F_ADD:   o_alu_control = ALU_ADD;
        F_SUB:   o_alu_control = ALU_SUB;
        F_AND:   o_alu_control = ALU_AND;
        F_OR:    o_alu_control = ALU_OR;
        F_SLT:   o_alu_control = ALU_SLT;
        default: o_funct_illegal = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore main controller sequencing lw/sw/R-type/beq/j through the multicycle datapath
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic [2:0]         alu_control,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);
  state_t     r_state, w_next;
  alu_op_t    w_alu_op;
  logic       w_funct_illegal;
  // zero is consumed by the datapath (pc_write_cond & zero), not by the sequencing here
  logic       w_unused_zero;
  assign w_unused_zero = zero;
  alu_decoder u_alu_decoder (
    .i_alu_op       (w_alu_op),
    .i_funct        (funct),
    .o_alu_control  (alu_control),
    .o_funct_illegal(w_funct_illegal)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_FETCH;
    else r_state <= w_next;
  always_comb begin
    w_next        = S_FETCH;
    w_alu_op      = ALUOP_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    // outputs stay quiet for the whole time reset is held, even though the state already reads FETCH
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          alu_src_b = 2'b01;
          pc_write  = 1'b1;
          w_next    = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW: w_next = S_MEM_ADDR;
            OP_RTYPE:     w_next = S_EXECUTE;
            OP_BEQ:       w_next = S_BRANCH;
            OP_J:         w_next = S_JUMP;
            default:      illegal_op = 1'b1;
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          w_next    = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          iord     = 1'b1;
          mem_read = 1'b1;
          w_next   = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a  = 1'b1;
          w_alu_op   = ALUOP_FUNCT;
          illegal_op = w_funct_illegal;
          w_next     = w_funct_illegal ? S_FETCH : S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          w_alu_op      = ALUOP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end
  assign state = STATE_W'(r_state);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream checked against a per-instruction state path and control table model
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic [2:0] alu_control;
  logic       alu_src_a, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
  logic       pc_write, pc_write_cond, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] state;
  logic [18:0] ctl;
  int n_chk = 0;
  int n_fail = 0;
  logic [5:0] legal_f [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );
  assign ctl = {alu_control, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write, reg_write,
                reg_dst, mem_to_reg, pc_write, pc_write_cond, pc_source, instr_done, illegal_op};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [3:0] fdec(input logic [5:0] fn);
    case (fn)
      6'h20:   return 4'b1010;
      6'h22:   return 4'b1110;
      6'h24:   return 4'b1000;
      6'h25:   return 4'b1001;
      6'h2a:   return 4'b1111;
      default: return 4'b0010;
    endcase
  endfunction
  function automatic logic op_ok(input logic [5:0] op);
    return op inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h02};
  endfunction
  function automatic logic [18:0] exp_ctl(input int s, input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] alu = 3'b010;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic sa = 0, io = 0, mr = 0, mw = 0, irw = 0, rw = 0, rd = 0, m2r = 0, pw = 0, pwc = 0, dn = 0, il = 0;
    logic [3:0] f = fdec(fn);
    case (s)
      0: begin mr = 1; irw = 1; sb = 2'b01; pw = 1; end
      1: begin sb = 2'b11; il = !op_ok(op); end
      2: begin sa = 1; sb = 2'b10; end
      3: begin io = 1; mr = 1; end
      4: begin rw = 1; m2r = 1; dn = 1; end
      5: begin io = 1; mw = 1; dn = 1; end
      6: begin sa = 1; alu = f[2:0]; il = !f[3]; end
      7: begin rw = 1; rd = 1; dn = 1; end
      8: begin sa = 1; alu = 3'b110; pwc = 1; ps = 2'b01; dn = 1; end
      9: begin pw = 1; ps = 2'b10; dn = 1; end
      default: ;
    endcase
    return {alu, sa, sb, io, mr, mw, irw, rw, rd, m2r, pw, pwc, ps, dn, il};
  endfunction
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int limit);
    int path[$];
    int dones = 0;
    logic [3:0] f = fdec(fn);
    case (op)
      6'h23:   path = '{0, 1, 2, 3, 4};
      6'h2b:   path = '{0, 1, 2, 5};
      6'h00:   path = f[3] ? '{0, 1, 6, 7} : '{0, 1, 6};
      6'h04:   path = '{0, 1, 8};
      6'h02:   path = '{0, 1, 9};
      default: path = '{0, 1};
    endcase
    for (int k = 0; k < path.size() && k < limit; k++) begin
      @(negedge clk);
      if (k == 0) begin opcode = op; funct = fn; zero = z; end
      #1;
      chk($sformatf("state op=%02h fn=%02h cyc%0d", op, fn, k), 32'(state), path[k]);
      chk($sformatf("ctl op=%02h fn=%02h st%0d", op, fn, path[k]), 32'(ctl), 32'(exp_ctl(path[k], op, fn)));
      chk("exclusive", {mem_read & mem_write, pc_write & pc_write_cond, instr_done & illegal_op}, 0);
      dones += int'(instr_done);
    end
    if (limit >= path.size())
      chk($sformatf("done_cnt op=%02h fn=%02h", op, fn), dones, (op_ok(op) && (op != 6'h00 || f[3])) ? 1 : 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_state", 32'(state), 0);
    chk("reset_ctl", 32'(ctl), 32'(exp_ctl(-1, 6'h0, 6'h0)));
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("reset_hold_state", 32'(state), 0);
      chk("reset_hold_ctl", 32'(ctl), 32'(exp_ctl(-1, 6'h0, 6'h0)));
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask
  initial begin
    logic [5:0] op, fn;
    #2 do_reset();
    run_instr(6'h23, 6'h00, 1'b0, 4);
    do_reset();
    run_instr(6'h23, 6'h00, 1'b0, 99);
    run_instr(6'h00, 6'h2a, 1'b0, 99);
    run_instr(6'h00, 6'h22, 1'b1, 99);
    run_instr(6'h00, 6'h24, 1'b0, 99);
    run_instr(6'h04, 6'h00, 1'b1, 99);
    run_instr(6'h04, 6'h00, 1'b0, 99);
    run_instr(6'h3f, 6'h00, 1'b0, 99);
    run_instr(6'h00, 6'h07, 1'b0, 99);
    run_instr(6'h2b, 6'h00, 1'b0, 99);
    run_instr(6'h02, 6'h00, 1'b0, 99);
    run_instr(6'h2b, 6'h00, 1'b0, 99);
    for (int i = 0; i < 150; i++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 6))
        0: op = 6'h23;
        1: op = 6'h2b;
        2: begin op = 6'h00; fn = legal_f[$urandom_range(0, 4)]; end
        3: begin op = 6'h00; while (fdec(fn) >= 4'd8) fn = 6'($urandom); end
        4: op = 6'h04;
        5: op = 6'h02;
        default: begin op = 6'($urandom); while (op_ok(op)) op = 6'($urandom); end
      endcase
      if ($urandom_range(0, 19) == 0) begin
        run_instr(op, fn, 1'($urandom), $urandom_range(1, 4));
        do_reset();
      end else run_instr(op, fn, 1'($urandom), 99);
    end
    @(negedge clk);
    #1;
    chk("final_state", 32'(state), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
